meas_scheduler: RTL and testbench

MEAS_SCHEDULER -- requirements
Module: meas_scheduler

---
 rtl/meas_sched_pkg.sv | 18 +
 rtl/meas_scheduler_if.sv | 30 +++
 rtl/meas_trig_timer.sv | 36 +++
 rtl/meas_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_meas_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/meas_sched_pkg.sv
// Shared types and constants for the measurement scheduler.
// Watchdog constants are used only when MEAS_SCHED_WDT_EN is defined.
package meas_sched_pkg;

    localparam int RANGE_W = 3;
    localparam int WDT_W   = 21;

    localparam logic [15:0]      UNDER_THR = 16'h0CCC;
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(1 << 20);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/meas_scheduler_if.sv
// Engine handshake bundle between the scheduler and the measurement engine.
// The scheduler side is master; the engine side is slave.
interface meas_scheduler_if #(
    parameter int CNT_W = 16
);
    import meas_sched_pkg::*;

    logic               meas_start;
    logic [RANGE_W-1:0] meas_range;
    logic               meas_done;
    logic [CNT_W-1:0]   meas_count;
    logic               meas_ovr;

    modport master (
        output meas_start,
        output meas_range,
        input  meas_done,
        input  meas_count,
        input  meas_ovr
    );

    modport slave (
        input  meas_start,
        input  meas_range,
        output meas_done,
        output meas_count,
        output meas_ovr
    );

endinterface

// File: rtl/meas_trig_timer.sv
// Free-running auto-trigger timer: counts 0..period-1, ticks on wrap.
// Held at zero while disabled or when the period is zero.
module meas_trig_timer #(
    parameter int PER_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [PER_W-1:0] period_i,
    output logic             tick_o
);

    logic [PER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = '0;
        tick_o = 1'b0;
        if (en_i && period_i != '0) begin
            // a count left above a freshly shortened period wraps at once
            if (cnt_q >= period_i - PER_W'(1)) begin
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/meas_scheduler.sv
// Measurement scheduler: arbitrates host/timer requests, averages samples, autoranges.
// Define MEAS_SCHED_WDT_EN to add the WAIT-state watchdog driving tmo_o.
module meas_scheduler
    import meas_sched_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PER_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cfg_en_i,
    input  logic [1:0]         cfg_avg_log2_i,
    input  logic [PER_W-1:0]   cfg_period_i,
    input  logic               cfg_autorange_i,
    input  logic [RANGE_W-1:0] cfg_range_i,
    input  logic               host_req_i,
    meas_scheduler_if.master   eng,
    output logic [CNT_W-1:0]   result_o,
    output logic [RANGE_W-1:0] result_range_o,
    output logic               result_valid_o,
    output logic               busy_o,
    output logic               ovf_o,
    output logic               tmo_o,
    output logic               drop_o
);

    localparam int ACC_W = CNT_W + 3;

    state_e             state_q, state_d;
    logic               host_q, host_d;
    logic               tmr_q, tmr_d;
    logic               drop_q, drop_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         avg_q, avg_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [RANGE_W-1:0] ret_q, ret_d;
    logic               up_q, up_d;
    logic               dn_q, dn_d;
    logic               ovf_q, ovf_d;

    logic               tick;
    logic               launch;
    logic               start;
    logic               valid;
    logic               under;
    logic               wdt_fire;
    logic [CNT_W-1:0]   res;

    meas_trig_timer #(.PER_W(PER_W)) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (cfg_en_i),
        .period_i(cfg_period_i),
        .tick_o  (tick)
    );

    assign under = 32'(eng.meas_count) < 32'(UNDER_THR);

    always_comb begin
        state_d = state_q;
        host_d  = host_q;
        tmr_d   = tmr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        range_d = range_q;
        ret_d   = ret_q;
        up_d    = up_q;
        dn_d    = dn_q;
        ovf_d   = ovf_q;
        launch  = 1'b0;
        start   = 1'b0;
        valid   = 1'b0;
        drop_d  = drop_q | (host_req_i & host_q) | (tick & tmr_q);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && (host_q || tmr_q)) begin
                    state_d = ST_START;
                    launch  = 1'b1;
                    if (host_q) host_d = 1'b0;
                    else        tmr_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    avg_d   = cfg_avg_log2_i;
                    range_d = cfg_autorange_i ? ret_q : cfg_range_i;
                    up_d    = 1'b0;
                    dn_d    = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_START: begin
                start   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng.meas_done) begin
                    if (eng.meas_ovr) begin
                        if (cfg_autorange_i && range_q != '1) begin
                            range_d = range_q + RANGE_W'(1);
                            acc_d   = '0;
                            cnt_d   = '0;
                            up_d    = 1'b1;
                            state_d = ST_START;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else if (cfg_autorange_i && under && range_q != '0
                                 && !up_q && !dn_q && cnt_q == '0) begin
                        range_d = range_q - RANGE_W'(1);
                        dn_d    = 1'b1;
                        state_d = ST_START;
                    end else begin
                        acc_d   = acc_q + ACC_W'(eng.meas_count);
                        cnt_d   = cnt_q + 4'd1;
                        state_d = (cnt_d == (4'd1 << avg_q)) ? ST_DONE : ST_START;
                    end
                end else if (wdt_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid   = 1'b1;
                ret_d   = range_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        host_d = host_d | host_req_i;
        tmr_d  = tmr_d | tick;

        // disabling aborts any conversion and forgets queued requests
        if (!cfg_en_i) begin
            host_d  = 1'b0;
            tmr_d   = 1'b0;
            state_d = ST_IDLE;
            start   = 1'b0;
            valid   = 1'b0;
            ret_d   = ret_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            host_q  <= 1'b0;
            tmr_q   <= 1'b0;
            drop_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            range_q <= '0;
            ret_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            host_q  <= host_d;
            tmr_q   <= tmr_d;
            drop_q  <= drop_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            range_q <= range_d;
            ret_q   <= ret_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MEAS_SCHED_WDT_EN
    logic [WDT_W-1:0] wdt_q;
    logic             tmo_q;

    assign wdt_fire = state_q == ST_WAIT && !eng.meas_done
                      && wdt_q == WDT_LIMIT - WDT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wdt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            wdt_q <= (state_q == ST_WAIT && !eng.meas_done) ? wdt_q + WDT_W'(1) : '0;
            if (launch)
                tmo_q <= 1'b0;
            else if (wdt_fire && cfg_en_i)
                tmo_q <= 1'b1;
        end
    end

    assign tmo_o = tmo_q;
`else
    assign wdt_fire = 1'b0;
    assign tmo_o    = 1'b0;
`endif

    assign res = (ovf_q || tmo_o) ? '0 : CNT_W'(acc_q >> avg_q);

    assign eng.meas_start = start;
    assign eng.meas_range = range_q;
    assign result_o       = valid ? res : '0;
    assign result_range_o = valid ? range_q : '0;
    assign result_valid_o = valid;
    assign busy_o         = state_q != ST_IDLE;
    assign ovf_o          = ovf_q;
    assign drop_o         = drop_q;

endmodule

// File: tb/tb_meas_scheduler.sv
// Scoreboard bench for meas_scheduler with a behavioural engine model.
// Default build: watchdog absent, tmo_o expected to stay 0.
module tb_meas_scheduler;
    import meas_sched_pkg::*;

    typedef struct {
        logic [15:0] cnt;
        logic        ovr;
    } smp_t;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rng;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  avg;
    logic [23:0] period;
    logic        auto_r;
    logic [2:0]  rng_cfg;
    logic        host_req;
    logic [15:0] result;
    logic [2:0]  result_range;
    logic        result_valid;
    logic        busy;
    logic        ovf;
    logic        tmo;
    logic        drop;

    meas_scheduler_if #(.CNT_W(16)) eif ();

    meas_scheduler #(.CNT_W(16), .PER_W(24)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cfg_en_i       (en),
        .cfg_avg_log2_i (avg),
        .cfg_period_i   (period),
        .cfg_autorange_i(auto_r),
        .cfg_range_i    (rng_cfg),
        .host_req_i     (host_req),
        .eng            (eif),
        .result_o       (result),
        .result_range_o (result_range),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .ovf_o          (ovf),
        .tmo_o          (tmo),
        .drop_o         (drop)
    );

    always #5 clk = ~clk;

    smp_t       smp_q[$];
    exp_t       exp_q[$];
    logic [2:0] rng_log[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_start = 0;
    int         n_valid = 0;
    int         n_pushed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic smp(input logic [15:0] c, input logic o);
        smp_t s;
        s.cnt = c;
        s.ovr = o;
        smp_q.push_back(s);
    endtask

    task automatic expect_res(input logic [15:0] r, input logic [2:0] g);
        exp_t e;
        e.res = r;
        e.rng = g;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_pulse();
        host_req = 1'b1;
        tick(1);
        host_req = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [2:0] r, input logic au);
        avg     = a;
        rng_cfg = r;
        auto_r  = au;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!(n_valid >= n_pushed && !busy) && k < 400) begin
            tick(1);
            k++;
        end
        if (k >= 400) chk("wait_timeout", n_valid, n_pushed);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, eif.meas_start, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_rrange"}, result_range, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_tmo"}, tmo, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_mrange"}, eif.meas_range, 0);
    endtask

    // engine model: answers each start pulse four cycles later
    initial begin
        int   dly;
        smp_t s;
        dly = 0;
        eif.meas_done  = 1'b0;
        eif.meas_count = '0;
        eif.meas_ovr   = 1'b0;
        forever begin
            @(negedge clk);
            eif.meas_done = 1'b0;
            eif.meas_ovr  = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0 && smp_q.size() > 0) begin
                    s = smp_q.pop_front();
                    eif.meas_done  = 1'b1;
                    eif.meas_count = s.cnt;
                    eif.meas_ovr   = s.ovr;
                end
            end
            if (eif.meas_start) begin
                n_start++;
                rng_log.push_back(eif.meas_range);
                dly = 4;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("result_range", result_range, e.rng);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int s0, v0;
        rst_n    = 1'b0;
        en       = 1'b1;
        period   = '0;
        host_req = 1'b0;
        cfg(2'd0, 3'd0, 1'b0);
        tick(3);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // four-sample average, manual range 2
        cfg(2'd2, 3'd2, 1'b0);
        smp(16'd100, 0); smp(16'd102, 0); smp(16'd104, 0); smp(16'd106, 0);
        expect_res(16'd103, 3'd2);
        s0 = n_start;
        host_pulse();
        wait_done();
        chk("avg4_starts", n_start - s0, 4);
        chk("avg4_busy", busy, 0);

        // two-sample average truncates
        cfg(2'd1, 3'd2, 1'b0);
        smp(16'd4001, 0); smp(16'd4002, 0);
        expect_res(16'd4001, 3'd2);
        host_pulse();
        wait_done();

        // autorange steps up from retained range 2
        cfg(2'd0, 3'd0, 1'b1);
        smp(16'd0, 1); smp(16'd5000, 0);
        expect_res(16'd5000, 3'd3);
        rng_log.delete();
        host_pulse();
        wait_done();
        chk("up_starts", rng_log.size(), 2);
        chk("up_rng0", rng_log[0], 3'd2);
        chk("up_rng1", rng_log[1], 3'd3);

        // overrange at top range
        cfg(2'd0, 3'd7, 1'b0);
        smp(16'd50, 0);
        expect_res(16'd50, 3'd7);
        host_pulse();
        wait_done();
        cfg(2'd0, 3'd0, 1'b1);
        smp(16'd0, 1);
        expect_res(16'd0, 3'd7);
        s0 = n_start;
        host_pulse();
        wait_done();
        chk("ovf_set", ovf, 1);
        chk("ovf_starts", n_start - s0, 1);
        chk("ovf_mrange", eif.meas_range, 3'd7);

        // single step-down from range 3
        cfg(2'd0, 3'd3, 1'b0);
        smp(16'd4000, 0);
        expect_res(16'd4000, 3'd3);
        host_pulse();
        wait_done();
        cfg(2'd0, 3'd0, 1'b1);
        smp(16'd100, 0); smp(16'd100, 0);
        expect_res(16'd100, 3'd2);
        rng_log.delete();
        host_pulse();
        wait_done();
        chk("dn_starts", rng_log.size(), 2);
        chk("dn_rng0", rng_log[0], 3'd3);
        chk("dn_rng1", rng_log[1], 3'd2);
        chk("dn_ovf_clr", ovf, 0);

        // host and timer in the same cycle, then a dropped host request
        cfg(2'd0, 3'd1, 1'b0);
        smp(16'd10, 0); smp(16'd20, 0); smp(16'd30, 0);
        expect_res(16'd10, 3'd1); expect_res(16'd20, 3'd1); expect_res(16'd30, 3'd1);
        s0 = n_start;
        period = 24'd4;
        tick(3);
        host_req = 1'b1;
        tick(1);
        host_req = 1'b0;
        period = '0;
        tick(2);
        host_req = 1'b1;
        tick(1);
        host_req = 1'b0;
        chk("drop_early", drop, 0);
        chk("arb_busy", busy, 1);
        tick(1);
        host_req = 1'b1;
        tick(1);
        host_req = 1'b0;
        chk("drop_set", drop, 1);
        wait_done();
        chk("arb_starts", n_start - s0, 3);

        // disable while waiting for the engine
        cfg(2'd0, 3'd1, 1'b0);
        host_pulse();
        tick(3);
        chk("dis_busy_before", busy, 1);
        en = 1'b0;
        tick(1);
        chk("dis_busy_after", busy, 0);
        s0 = n_start;
        v0 = n_valid;
        tick(10);
        chk("dis_no_valid", n_valid, v0);
        chk("dis_no_start", n_start, s0);
        en = 1'b1;
        tick(2);

        // reset in WAIT; the late engine done must be ignored
        smp(16'd777, 0);
        host_pulse();
        tick(2);
        chk("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_zero("midrst");
        v0 = n_valid;
        tick(10);
        chk("midrst_no_valid", n_valid, v0);
        chk("midrst_idle", busy, 0);

        // retained range was cleared by reset
        cfg(2'd0, 3'd5, 1'b1);
        smp(16'd5000, 0);
        expect_res(16'd5000, 3'd0);
        host_pulse();
        wait_done();

        // eight full-scale samples do not overflow
        cfg(2'd3, 3'd5, 1'b0);
        for (int i = 0; i < 8; i++) smp(16'hFFFF, 0);
        expect_res(16'hFFFF, 3'd5);
        s0 = n_start;
        host_pulse();
        wait_done();
        chk("avg8_starts", n_start - s0, 8);
        chk("tmo_low", tmo, 0);

        tick(5);
        chk("exp_left", exp_q.size(), 0);
        chk("smp_left", smp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
